gbf_fill_scheduler: RTL and testbench

Sequences refills of the accelerator's four double-buffered global buffers (activation GBF1/GBF2, weight GBF1/GBF2) from an external memory port. Watches the per-buffer `need_data` levels, grants one buffer at a time round-robin, and issues a burst request. It streams `GBF_DEPTH` returned words into the granted buffer's write port, then signals completion. Sits between the off-chip memory interface and the accelerator's GBF write ports.

---
 rtl/gbf_sched_pkg.sv | 23 ++
 rtl/gbf_fill_scheduler_if.sv | 29 ++
 rtl/gbf_fill_scheduler_arb.sv | 29 ++
 rtl/gbf_fill_scheduler.sv | 153 +++++++++++++++
 tb/tb_gbf_fill_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gbf_sched_pkg.sv
// gbf_sched_pkg: shared definitions for the GBF fill scheduler.
//   state_e          : scheduler FSM encoding (IDLE=0, REQ=1, XFER=2, DONE=3)
//   ACTV1..WGT2      : requester indices, matching need_data/gbf_w_en/fill_done bit order
//   idx2onehot()     : 2-bit requester index to 4-bit one-hot vector
package gbf_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] ACTV1 = 2'd0;
    localparam logic [1:0] ACTV2 = 2'd1;
    localparam logic [1:0] WGT1  = 2'd2;
    localparam logic [1:0] WGT2  = 2'd3;

    function automatic logic [3:0] idx2onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/gbf_fill_scheduler_if.sv
// gbf_fill_scheduler_if: external memory port of the GBF fill scheduler.
//   mem_req_valid/ready/addr/len : burst request channel (scheduler -> memory)
//   mem_rd_valid/ready/data      : return beat channel (memory -> scheduler)
//   modport master : scheduler side; modport slave : memory side
interface gbf_fill_scheduler_if #(
    parameter int unsigned DATA_W     = 256,
    parameter int unsigned MEM_ADDR_W = 32,
    parameter int unsigned LEN_W      = 6
) ();

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [MEM_ADDR_W-1:0] mem_req_addr;
    logic [LEN_W-1:0]      mem_req_len;
    logic                  mem_rd_valid;
    logic                  mem_rd_ready;
    logic [DATA_W-1:0]     mem_rd_data;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_len, mem_rd_ready,
        input  mem_req_ready, mem_rd_valid, mem_rd_data
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_len, mem_rd_ready,
        output mem_req_ready, mem_rd_valid, mem_rd_data
    );

endinterface

// File: rtl/gbf_fill_scheduler_arb.sv
// rr_arbiter4: combinational 4-way round-robin arbiter.
//   req       in  4 : request vector
//   ptr       in  2 : highest-priority index this round
//   grant     out 4 : one-hot grant (all zero if no request)
//   grant_idx out 2 : index of the granted requester (ptr when no request)
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] grant,
    output logic [1:0] grant_idx
);

    logic [1:0] idx;

    // Scan ptr, ptr+1, ... (mod 4); the first set request wins.
    always_comb begin
        grant     = '0;
        grant_idx = ptr;
        idx       = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (req[idx] && (grant == '0)) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/gbf_fill_scheduler.sv
// gbf_fill_scheduler: refills the four double-buffered GBFs (actv1, actv2,
// wgt1, wgt2) from external memory, one buffer at a time, round-robin.
//   clk, reset   : clock, synchronous active-high reset
//   en           : permits new grants (an ongoing burst always completes)
//   need_data    : per-buffer refill level requests
//   mem          : memory burst request / return beat port (master side)
//   gbf_w_en/addr/data : registered one-hot GBF write port
//   fill_done    : one-cycle pulse for the buffer just completed
//   busy         : FSM not in IDLE
module gbf_fill_scheduler
    import gbf_sched_pkg::*;
#(
    parameter int unsigned GBF_DATA_BITWIDTH = 256,
    parameter int unsigned GBF_ADDR_BITWIDTH = 5,
    parameter int unsigned GBF_DEPTH         = 32,
    parameter int unsigned MEM_ADDR_BITWIDTH = 32,
    parameter logic [MEM_ADDR_BITWIDTH-1:0] ACTV_BASE = '0,
    parameter logic [MEM_ADDR_BITWIDTH-1:0] WGT_BASE  = 'h10000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [3:0]                    need_data,
    gbf_fill_scheduler_if.master          mem,
    output logic [3:0]                    gbf_w_en,
    output logic [GBF_ADDR_BITWIDTH-1:0]  gbf_w_addr,
    output logic [GBF_DATA_BITWIDTH-1:0]  gbf_w_data,
    output logic [3:0]                    fill_done,
    output logic                          busy
);

    localparam logic [GBF_ADDR_BITWIDTH-1:0] LAST_BEAT  = GBF_ADDR_BITWIDTH'(GBF_DEPTH - 1);
    localparam logic [MEM_ADDR_BITWIDTH-1:0] PTR_STEP   = MEM_ADDR_BITWIDTH'(GBF_DEPTH);
    localparam logic [GBF_ADDR_BITWIDTH:0]   BURST_LEN  = (GBF_ADDR_BITWIDTH + 1)'(GBF_DEPTH);

    state_e                         state_q, state_d;
    logic [1:0]                     sel_q, sel_d;
    logic [1:0]                     rr_ptr_q, rr_ptr_d;
    logic [MEM_ADDR_BITWIDTH-1:0]   actv_ptr_q, actv_ptr_d;
    logic [MEM_ADDR_BITWIDTH-1:0]   wgt_ptr_q, wgt_ptr_d;
    logic [GBF_ADDR_BITWIDTH-1:0]   beat_q, beat_d;
    logic                           mask_q, mask_d;
    logic [3:0]                     w_en_q, w_en_d;
    logic [GBF_ADDR_BITWIDTH-1:0]   w_addr_q, w_addr_d;
    logic [GBF_DATA_BITWIDTH-1:0]   w_data_q, w_data_d;

    logic [3:0] eligible;
    logic [3:0] arb_grant;
    logic [1:0] arb_idx;
    logic       beat_fire;
    logic       sel_is_wgt;

    // The buffer just filled gets one IDLE cycle to drop its level.
    assign eligible   = need_data & ~(mask_q ? idx2onehot(sel_q) : 4'b0000);
    assign beat_fire  = (state_q == ST_XFER) && mem.mem_rd_valid;
    assign sel_is_wgt = (sel_q == WGT1) || (sel_q == WGT2);

    rr_arbiter4 u_arb (
        .req       (eligible),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            rr_ptr_q   <= '0;
            actv_ptr_q <= ACTV_BASE;
            wgt_ptr_q  <= WGT_BASE;
            beat_q     <= '0;
            mask_q     <= 1'b0;
            w_en_q     <= '0;
            w_addr_q   <= '0;
            w_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            rr_ptr_q   <= rr_ptr_d;
            actv_ptr_q <= actv_ptr_d;
            wgt_ptr_q  <= wgt_ptr_d;
            beat_q     <= beat_d;
            mask_q     <= mask_d;
            w_en_q     <= w_en_d;
            w_addr_q   <= w_addr_d;
            w_data_q   <= w_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rr_ptr_d   = rr_ptr_q;
        actv_ptr_d = actv_ptr_q;
        wgt_ptr_d  = wgt_ptr_q;
        beat_d     = beat_q;
        mask_d     = 1'b0;
        w_en_d     = '0;
        w_addr_d   = w_addr_q;
        w_data_d   = w_data_q;

        if (beat_fire) begin
            w_en_d   = idx2onehot(sel_q);
            w_addr_d = beat_q;
            w_data_d = mem.mem_rd_data;
            beat_d   = beat_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (en && (arb_grant != '0)) begin
                    sel_d   = arb_idx;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem.mem_req_ready) begin
                    state_d = ST_XFER;
                    beat_d  = '0;
                end
            end
            ST_XFER: begin
                if (beat_fire && (beat_q == LAST_BEAT)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (sel_is_wgt) begin
                    wgt_ptr_d = wgt_ptr_q + PTR_STEP;
                end else begin
                    actv_ptr_d = actv_ptr_q + PTR_STEP;
                end
                rr_ptr_d = sel_q + 2'd1;
                mask_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem.mem_req_valid = (state_q == ST_REQ);
    assign mem.mem_req_addr  = (state_q != ST_REQ) ? '0 : (sel_is_wgt ? wgt_ptr_q : actv_ptr_q);
    assign mem.mem_req_len   = (state_q == ST_REQ) ? BURST_LEN : '0;
    assign mem.mem_rd_ready  = (state_q == ST_XFER);

    assign gbf_w_en   = w_en_q;
    assign gbf_w_addr = w_addr_q;
    assign gbf_w_data = w_data_q;
    assign fill_done  = (state_q == ST_DONE) ? idx2onehot(sel_q) : 4'b0000;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gbf_fill_scheduler.sv
// tb_gbf_fill_scheduler: directed scoreboard bench for gbf_fill_scheduler.
module tb_gbf_fill_scheduler;

    localparam int unsigned DW    = 256;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned MAW   = 32;
    localparam logic [31:0] ACTV_B = 32'h0;
    localparam logic [31:0] WGT_B  = 32'h10000;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           en = 1'b0;
    logic [3:0]     need_data = 4'b0000;
    logic [3:0]     gbf_w_en;
    logic [AW-1:0]  gbf_w_addr;
    logic [DW-1:0]  gbf_w_data;
    logic [3:0]     fill_done;
    logic           busy;

    gbf_fill_scheduler_if #(.DATA_W(DW), .MEM_ADDR_W(MAW), .LEN_W(AW + 1)) mem_bus ();

    gbf_fill_scheduler #(
        .GBF_DATA_BITWIDTH (DW),
        .GBF_ADDR_BITWIDTH (AW),
        .GBF_DEPTH         (DEPTH),
        .MEM_ADDR_BITWIDTH (MAW),
        .ACTV_BASE         (ACTV_B),
        .WGT_BASE          (WGT_B)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .need_data  (need_data),
        .mem        (mem_bus),
        .gbf_w_en   (gbf_w_en),
        .gbf_w_addr (gbf_w_addr),
        .gbf_w_data (gbf_w_data),
        .fill_done  (fill_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef enum int {EV_REQ, EV_WR, EV_DONE} ev_e;
    typedef struct {
        ev_e            kind;
        logic [31:0]    addr;
        logic [3:0]     en;
        logic [DW-1:0]  data;
    } exp_t;
    exp_t exp_q[$];

    function automatic logic [DW-1:0] beat_word(input int unsigned burst, input int unsigned idx);
        logic [DW-1:0] w;
        w = '0;
        w[31:0]    = idx;
        w[63:32]   = burst;
        w[255:224] = 32'hC0DE0000 | burst;
        return w;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push_fill(input int unsigned sel, input logic [31:0] addr, input int unsigned burst,
                             input int unsigned nbeats, input bit with_done);
        exp_t e;
        e.kind = EV_REQ; e.addr = addr; e.en = '0; e.data = '0;
        exp_q.push_back(e);
        for (int unsigned i = 0; i < nbeats; i++) begin
            e.kind = EV_WR; e.addr = i; e.en = 4'b0001 << sel; e.data = beat_word(burst, i);
            exp_q.push_back(e);
        end
        if (with_done) begin
            e.kind = EV_DONE; e.addr = '0; e.en = 4'b0001 << sel; e.data = '0;
            exp_q.push_back(e);
        end
    endtask

    // Memory model: inputs change 1 time unit after the rising edge.
    int unsigned req_delay = 0;
    bit          toggle_mode = 1'b0;
    bit          bursting = 1'b0;
    bit          ph = 1'b0;
    int unsigned req_wait = 0;
    int unsigned beat_idx = 0;
    int unsigned burst_no = 0;

    initial begin
        mem_bus.mem_req_ready = 1'b0;
        mem_bus.mem_rd_valid  = 1'b0;
        mem_bus.mem_rd_data   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                mem_bus.mem_req_ready = 1'b0;
                mem_bus.mem_rd_valid  = 1'b0;
                bursting = 1'b0; ph = 1'b0;
                req_wait = 0; beat_idx = 0; burst_no = 0;
            end else begin
                if (mem_bus.mem_rd_valid) begin
                    beat_idx++;
                    mem_bus.mem_rd_valid = 1'b0;
                end
                if (mem_bus.mem_req_ready) begin
                    mem_bus.mem_req_ready = 1'b0;
                    bursting = 1'b1; beat_idx = 0; ph = 1'b0;
                end else if (!bursting && mem_bus.mem_req_valid) begin
                    if (req_wait >= req_delay) mem_bus.mem_req_ready = 1'b1;
                    else req_wait++;
                end
                if (bursting) begin
                    if (beat_idx >= DEPTH) begin
                        bursting = 1'b0; req_wait = 0; burst_no++;
                    end else begin
                        if (!toggle_mode || !ph) begin
                            mem_bus.mem_rd_valid = 1'b1;
                            mem_bus.mem_rd_data  = beat_word(burst_no, beat_idx);
                        end
                        ph = toggle_mode ? ~ph : 1'b0;
                    end
                end
            end
        end
    end

    task automatic expect_event(input ev_e kind, input logic [31:0] addr, input logic [3:0] enx,
                                input logic [DW-1:0] data);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d addr %0h en %b, expected nothing", kind, addr, enx);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.addr != addr || e.en != enx || e.data != data) begin
            errors++;
            $display("FAIL scoreboard: got kind %0d addr %0h en %b data %0h expected kind %0d addr %0h en %b data %0h",
                     kind, addr, enx, data, e.kind, e.addr, e.en, e.data);
        end
    endtask

    // Monitor: samples on the falling edge; a handshake seen here completes on the next rising edge.
    bit          prev_pending = 1'b0;
    logic [31:0] prev_addr = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_pending = 1'b0;
            end else begin
                if (prev_pending) begin
                    checks++;
                    if (!(mem_bus.mem_req_valid && mem_bus.mem_req_addr == prev_addr)) begin
                        errors++;
                        $display("FAIL req_hold: got valid %b addr %0h expected valid 1 addr %0h",
                                 mem_bus.mem_req_valid, mem_bus.mem_req_addr, prev_addr);
                    end
                end
                prev_pending = mem_bus.mem_req_valid && !mem_bus.mem_req_ready;
                prev_addr    = mem_bus.mem_req_addr;
            end
            if (mem_bus.mem_req_valid && mem_bus.mem_req_ready) begin
                expect_event(EV_REQ, mem_bus.mem_req_addr, 4'b0000, '0);
                chk("req_len", 256'(mem_bus.mem_req_len), 256'(DEPTH));
            end
            if (gbf_w_en != 4'b0000) expect_event(EV_WR, 32'(gbf_w_addr), gbf_w_en, gbf_w_data);
            if (fill_done != 4'b0000) expect_event(EV_DONE, 32'h0, fill_done, '0);
        end
    end

    task automatic do_reset();
        reset = 1'b1; en = 1'b0; need_data = 4'b0000;
        req_delay = 0; toggle_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Waits for a fill_done pulse; the final write must be on the write port in the same cycle.
    task automatic wait_fill(output logic [3:0] fd, input int unsigned limit);
        fd = 4'b0000;
        for (int unsigned n = 0; n < limit; n++) begin
            @(posedge clk);
            #1;
            if (fill_done != 4'b0000) begin
                fd = fill_done;
                chk("done_with_last_write", {gbf_w_en, 27'(gbf_w_addr)}, {fill_done, 27'(DEPTH - 1)});
                return;
            end
        end
        checks++; errors++;
        $display("FAIL fill_timeout: got no fill_done expected one within %0d cycles", limit);
    endtask

    task automatic wait_drain(input int unsigned limit);
        for (int unsigned n = 0; n < limit; n++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !busy) return;
        end
        checks++; errors++;
        $display("FAIL drain_timeout: got %0d pending events busy %b expected 0 pending idle", exp_q.size(), busy);
    endtask

    task automatic wait_write_addr(input int unsigned a, input int unsigned limit);
        for (int unsigned n = 0; n < limit; n++) begin
            @(posedge clk);
            #1;
            if (gbf_w_en != 4'b0000 && gbf_w_addr == AW'(a)) return;
        end
        checks++; errors++;
        $display("FAIL write_timeout: got no write at addr %0d expected one", a);
    endtask

    initial begin
        logic [3:0]  fd;
        int unsigned n;

        // Reset values
        repeat (2) @(negedge clk);
        chk("reset_outputs",
            {busy, mem_bus.mem_req_valid, mem_bus.mem_rd_ready, fill_done, gbf_w_en, gbf_w_addr,
             mem_bus.mem_req_addr, mem_bus.mem_req_len}, '0);
        chk("reset_wdata", gbf_w_data, '0);
        do_reset();

        // Single request to actv_gbf1
        push_fill(0, ACTV_B, 0, DEPTH, 1'b1);
        en = 1'b1; need_data = 4'b0001;
        @(posedge clk);
        #1;
        chk("grant_latency", 256'(mem_bus.mem_req_valid), 256'(1));
        wait_fill(fd, 200);
        need_data = 4'b0000;
        wait_drain(100);

        // Round-robin over all four with a shared pointer per stream
        do_reset();
        push_fill(0, ACTV_B,           0, DEPTH, 1'b1);
        push_fill(1, ACTV_B + 32'd32,  1, DEPTH, 1'b1);
        push_fill(2, WGT_B,            2, DEPTH, 1'b1);
        push_fill(3, WGT_B + 32'h20,   3, DEPTH, 1'b1);
        en = 1'b1; need_data = 4'b1111;
        n = 0;
        while (need_data != 4'b0000 && n < 400) begin
            @(posedge clk);
            #1;
            need_data = need_data & ~fill_done;
            n++;
        end
        chk("rr_all_served", 256'(need_data), 256'(0));
        wait_drain(100);

        // Backpressure: late request ready, return beats every other cycle
        do_reset();
        req_delay = 5; toggle_mode = 1'b1;
        push_fill(2, WGT_B, 0, DEPTH, 1'b1);
        en = 1'b1; need_data = 4'b0100;
        wait_fill(fd, 300);
        chk("bp_fill_done", 256'(fd), 256'(4'b0100));
        need_data = 4'b0000;
        wait_drain(100);

        // Enable gating mid-burst
        do_reset();
        push_fill(0, ACTV_B, 0, DEPTH, 1'b1);
        en = 1'b1; need_data = 4'b0011;
        wait_write_addr(10, 200);
        en = 1'b0;
        wait_fill(fd, 200);
        chk("gate_fill_done", 256'(fd), 256'(4'b0001));
        need_data = 4'b0010;
        repeat (20) @(posedge clk);
        #1;
        chk("gate_no_grant", {busy, mem_bus.mem_req_valid}, '0);
        push_fill(1, ACTV_B + 32'd32, 1, DEPTH, 1'b1);
        en = 1'b1;
        wait_fill(fd, 200);
        need_data = 4'b0000;
        wait_drain(100);

        // Reset in the middle of a burst
        do_reset();
        push_fill(0, ACTV_B, 0, 15, 1'b0);
        en = 1'b1; need_data = 4'b0001;
        wait_write_addr(14, 200);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midburst_reset_outputs",
            {busy, mem_bus.mem_req_valid, mem_bus.mem_rd_ready, fill_done, gbf_w_en, gbf_w_addr,
             mem_bus.mem_req_addr, mem_bus.mem_req_len}, '0);
        chk("midburst_reset_wdata", gbf_w_data, '0);
        chk("midburst_flushed", 256'(exp_q.size()), 256'(0));
        push_fill(0, ACTV_B, 0, DEPTH, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_fill(fd, 200);
        need_data = 4'b0000;
        wait_drain(100);

        // Mask: a level held past fill_done is skipped for one IDLE cycle
        do_reset();
        push_fill(0, ACTV_B,          0, DEPTH, 1'b1);
        push_fill(0, ACTV_B + 32'd32, 1, DEPTH, 1'b1);
        en = 1'b1; need_data = 4'b0001;
        wait_fill(fd, 200);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!mem_bus.mem_req_valid && n < 10);
        chk("mask_regrant_gap", 256'(n), 256'(3));
        wait_fill(fd, 200);
        need_data = 4'b0000;
        wait_drain(100);

        chk("queue_empty_end", 256'(exp_q.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion expected finish before 200000");
        $fatal(1);
    end

endmodule
